// File: rtl/reg_cmd_ctrl_if.sv
// Bus bundle between the command controller and its surroundings: the UART
// receiver/transmitter byte ports and the register-file port.
interface reg_cmd_ctrl_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDR      = 4
);
    logic [DATAWIDTH-1:0] RX_P_Data;
    logic                 RX_D_VLD;
    logic [DATAWIDTH-1:0] RdData;
    logic                 RdData_Valid;
    logic                 TX_Busy;
    logic                 WrEn;
    logic                 RdEn;
    logic [ADDR-1:0]      Address;
    logic [DATAWIDTH-1:0] WrData;
    logic [DATAWIDTH-1:0] TX_P_Data;
    logic                 TX_D_VLD;
    logic                 Cmd_Err;

    // Controller side
    modport master (
        input  RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
        output WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD, Cmd_Err
    );

    // Environment side (UART + register file)
    modport slave (
        output RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
        input  WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD, Cmd_Err
    );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Command-frame controller: decodes write (opcode, addr, data) and read
// (opcode, addr) frames from the UART receiver, drives the register-file
// port and returns read data to the UART transmitter. All outputs registered.
module reg_cmd_ctrl #(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   ADDR       = 4,
    parameter int                   RD_TIMEOUT = 15,
    parameter logic [DATAWIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATAWIDTH-1:0] RD_CMD     = 8'hBB
) (
    input  logic           CLK,
    input  logic           RST,
    reg_cmd_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR-1:0]      addr_q, addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH-1:0] txdata_q, txdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wren_q, wren_d;
    logic                 rden_q, rden_d;
    logic                 txvld_q, txvld_d;
    logic                 err_q, err_d;
    logic                 addr_bad;

    // An address byte is rejected when any bit above the address field is set
    assign addr_bad = |bus.RX_P_Data[DATAWIDTH-1:ADDR];

    // State and output registers; reset clears everything, including data
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            txdata_q <= '0;
            cnt_q    <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txvld_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            txdata_q <= txdata_d;
            cnt_q    <= cnt_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txvld_q  <= txvld_d;
            err_q    <= err_d;
        end
    end

    // Next-state decode; pulse outputs default low, data holds its value
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        txdata_d = txdata_q;
        cnt_d    = cnt_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txvld_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_Data == WR_CMD)      state_d = WR_ADDR;
                    else if (bus.RX_P_Data == RD_CMD) state_d = RD_ADDR;
                    else                              err_d   = 1'b1;
                end
            end
            WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = bus.RX_P_Data[ADDR-1:0];
                        state_d = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wdata_d = bus.RX_P_Data;
                    wren_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = bus.RX_P_Data[ADDR-1:0];
                        rden_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Read data wins over a timeout landing in the same cycle
                if (bus.RdData_Valid) begin
                    txdata_d = bus.RdData;
                    txvld_d  = 1'b1;
                    state_d  = TX_SEND;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Bytes arriving mid-transaction are dropped and flagged
                if (bus.RX_D_VLD) err_d = 1'b1;
            end
            TX_SEND: begin
                if (bus.TX_Busy) txvld_d = 1'b1;
                else             state_d = IDLE;
                if (bus.RX_D_VLD) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.WrEn      = wren_q;
    assign bus.RdEn      = rden_q;
    assign bus.Address   = addr_q;
    assign bus.WrData    = wdata_q;
    assign bus.TX_P_Data = txdata_q;
    assign bus.TX_D_VLD  = txvld_q;
    assign bus.Cmd_Err   = err_q;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Testbench for reg_cmd_ctrl: cycle-by-cycle vector table plus hand-written
// timeout and mid-frame-reset sequences. Includes a small register-file model
// that answers RdEn with RdData_Valid one cycle later.
module tb_reg_cmd_ctrl;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic CLK;
    logic RST;

    reg_cmd_ctrl_if #(.DATAWIDTH(8), .ADDR(4)) bus ();

    reg_cmd_ctrl #(
        .DATAWIDTH(8), .ADDR(4), .RD_TIMEOUT(15), .WR_CMD(8'hAA), .RD_CMD(8'hBB)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] byt;
        logic       busy;
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] wd;
        logic       tv;
        logic [7:0] td;
        logic       er;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] mem [16];
    logic       rf_en;
    logic       rd_pend;
    int         n_checks;
    int         n_fail;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-file model: RdEn seen in one cycle -> RdData_Valid in the next
    always @(negedge CLK) rd_pend = rf_en && bus.RdEn;
    always @(posedge CLK) begin
        #1;
        bus.RdData_Valid = rd_pend;
        bus.RdData       = rd_pend ? mem[bus.Address] : 8'h00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(logic rst, logic vld, logic [7:0] b, logic busy,
                               logic we, logic re, logic [3:0] a, logic [7:0] wd,
                               logic tv, logic [7:0] td, logic er);
        vec_t r;
        r.rst = rst; r.vld = vld; r.byt = b; r.busy = busy;
        r.we = we; r.re = re; r.addr = a; r.wd = wd; r.tv = tv; r.td = td; r.er = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.RX_D_VLD  = 1'b1;
        bus.RX_P_Data = b;
        tick();
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_Data = 8'h00;
    endtask

    initial begin
        int   k;
        logic saw_tx;
        logic saw_we;
        logic [31:0] act, exp;

        n_checks = 0;
        n_fail   = 0;
        RST = 1'b1;
        rf_en = 1'b1;
        rd_pend = 1'b0;
        bus.RX_D_VLD = 1'b0;
        bus.RX_P_Data = 8'h00;
        bus.TX_Busy = 1'b0;
        bus.RdData_Valid = 1'b0;
        bus.RdData = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[2] = 8'h21;
        mem[5] = 8'h9A;

        // Row inputs apply during one cycle; expectations are the outputs of the next.
        // rst vld  byte  busy | we re addr  wdata tv  txdata err
        vq.push_back(v(H, L, 8'h00, L,  L, L, 4'h0, 8'h00, L, 8'h00, L));
        vq.push_back(v(H, L, 8'h00, L,  L, L, 4'h0, 8'h00, L, 8'h00, L));
        vq.push_back(v(L, H, 8'hAA, L,  L, L, 4'h0, 8'h00, L, 8'h00, L));
        vq.push_back(v(L, H, 8'h03, L,  L, L, 4'h3, 8'h00, L, 8'h00, L));
        vq.push_back(v(L, H, 8'h5C, L,  H, L, 4'h3, 8'h5C, L, 8'h00, L));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h3, 8'h5C, L, 8'h00, L));
        vq.push_back(v(L, H, 8'hBB, L,  L, L, 4'h3, 8'h5C, L, 8'h00, L));
        vq.push_back(v(L, H, 8'h02, L,  L, H, 4'h2, 8'h5C, L, 8'h00, L));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h2, 8'h5C, L, 8'h00, L));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h2, 8'h5C, H, 8'h21, L));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h2, 8'h5C, L, 8'h21, L));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h2, 8'h5C, L, 8'h21, L));
        vq.push_back(v(L, H, 8'hBB, H,  L, L, 4'h2, 8'h5C, L, 8'h21, L));
        vq.push_back(v(L, H, 8'h05, H,  L, H, 4'h5, 8'h5C, L, 8'h21, L));
        vq.push_back(v(L, L, 8'h00, H,  L, L, 4'h5, 8'h5C, L, 8'h21, L));
        vq.push_back(v(L, L, 8'h00, H,  L, L, 4'h5, 8'h5C, H, 8'h9A, L));
        for (int i = 0; i < 5; i++)
            vq.push_back(v(L, L, 8'h00, H,  L, L, 4'h5, 8'h5C, H, 8'h9A, L));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, L));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, L));
        vq.push_back(v(L, H, 8'h7E, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, H));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, L));
        vq.push_back(v(L, H, 8'hAA, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, L));
        vq.push_back(v(L, H, 8'h13, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, H));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, L));
        vq.push_back(v(L, H, 8'hBB, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, L));
        vq.push_back(v(L, H, 8'h13, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, H));
        vq.push_back(v(L, L, 8'h00, L,  L, L, 4'h5, 8'h5C, L, 8'h9A, L));

        tick();
        foreach (vq[i]) begin
            RST           = vq[i].rst;
            bus.RX_D_VLD  = vq[i].vld;
            bus.RX_P_Data = vq[i].byt;
            bus.TX_Busy   = vq[i].busy;
            tick();
            act = {8'h00, bus.WrEn, bus.RdEn, bus.Address, bus.WrData,
                   bus.TX_D_VLD, bus.TX_P_Data, bus.Cmd_Err};
            exp = {8'h00, vq[i].we, vq[i].re, vq[i].addr, vq[i].wd,
                   vq[i].tv, vq[i].td, vq[i].er};
            chk($sformatf("vec%0d {we,re,addr,wd,tv,td,err}", i), act, exp);
        end
        RST = 1'b0;
        bus.RX_D_VLD = 1'b0;
        bus.TX_Busy = 1'b0;
        tick();

        // Timeout: no read response, Cmd_Err expected 16 cycles after RdEn
        rf_en = 1'b0;
        send(8'hBB);
        send(8'h01);
        chk("timeout_rden", 32'(bus.RdEn), 32'd1);
        k = 0;
        saw_tx = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.TX_D_VLD) saw_tx = 1'b1;
            if (bus.Cmd_Err) begin
                k = c;
                break;
            end
        end
        chk("timeout_delay", 32'(k), 32'd16);
        chk("timeout_no_tx", 32'(saw_tx), 32'd0);
        tick();
        chk("timeout_err_one_cycle", 32'(bus.Cmd_Err), 32'd0);
        rf_en = 1'b1;
        send(8'hAA);
        send(8'h01);
        send(8'hFF);
        chk("post_timeout_write", {22'h0, bus.WrEn, bus.Cmd_Err, bus.WrData},
            {22'h0, 1'b1, 1'b0, 8'hFF});
        chk("post_timeout_addr", 32'(bus.Address), 32'd1);
        tick();
        chk("post_timeout_wren_pulse", 32'(bus.WrEn), 32'd0);

        // Mid-frame reset abandons the write; 0x99 is then a bad opcode
        send(8'hAA);
        send(8'h04);
        chk("midreset_addr_latched", 32'(bus.Address), 32'd4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("midreset_cleared", {16'h0, bus.Address, bus.WrData, bus.WrEn, bus.Cmd_Err, 2'b00},
            32'd0);
        send(8'h99);
        chk("midreset_err_99", {30'h0, bus.Cmd_Err, bus.WrEn}, {30'h0, 1'b1, 1'b0});
        saw_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.WrEn || bus.RdEn || bus.TX_D_VLD) saw_we = 1'b1;
        end
        chk("midreset_no_pulses", 32'(saw_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
